serializador: RTL and testbench

//  Transmit end of the bit-serial byte link: accepts parallel bytes from the local producer,

---
 rtl/serializador_pkg.sv | 22 ++
 rtl/serializador_if.sv | 25 ++
 rtl/serializador_fifo.sv | 57 +++++
 rtl/serializador.sv | 122 ++++++++++++
 tb/tb_serializador.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/serializador_pkg.sv
// Shared types for the serializador transmit block: FSM states and WAIT_RX handshake phase.
package serializador_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_RX = 2'd2
  } state_t;

  // WAIT_RX first waits for the far end to raise status, then for it to drop it again.
  typedef enum logic {
    RX_WAIT_RISE = 1'b0,
    RX_WAIT_FALL = 1'b1
  } rx_phase_t;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serializador_if.sv
// Producer-side parallel handshake plus the serial link towards the far-end deserializador.
interface serializador_if
  import serializador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] data_in;
  logic             write_in;
  logic             ready_out;
  logic             status_in;
  logic             data_out;
  logic             write_out;
  logic             busy_out;
  logic             error_out;

  modport slave (
    input  data_in, write_in, status_in,
    output ready_out, data_out, write_out, busy_out, error_out
  );

  modport master (
    output data_in, write_in, status_in,
    input  ready_out, data_out, write_out, busy_out, error_out
  );
endinterface

// File: rtl/serializador_fifo.sv
// Small synchronous input FIFO; head word is readable combinationally so a pop loads it the same edge.
module serializador_fifo
  import serializador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk_100KHz,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             ready_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q;
  logic             do_push, do_pop;

  // ready_q is only low when full, so gating on it alone blocks overwrites.
  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && !empty_o;
  assign empty_o = (count_q == '0);
  assign ready_o = ready_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_100KHz) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/serializador.sv
// Bit-serial byte transmitter: FIFO -> MSB-first shifter -> two-phase far-end acknowledge.
// Optional WAIT_RX watchdog and sticky error_out enabled by defining SERIALIZADOR_TIMEOUT_EN.
module serializador
  import serializador_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk_100KHz,
  input  logic          reset,
  serializador_if.slave bus
);
  localparam int BCW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  rx_phase_t        phase_q, phase_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             timeout_hit;

  serializador_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .push_i     (bus.write_in),
    .data_i     (bus.data_in),
    .pop_i      (fifo_pop),
    .data_o     (fifo_data),
    .empty_o    (fifo_empty),
    .ready_o    (bus.ready_out)
  );

  // A new word only leaves once the far end has released the previous one.
  assign fifo_pop = (state_q == IDLE) && !fifo_empty && !bus.status_in;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          shift_d   = fifo_data;
          bit_cnt_d = BCW'(WIDTH);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q - 1'b1;
        if (bit_cnt_q == BCW'(1)) begin
          state_d = WAIT_RX;
          phase_d = RX_WAIT_RISE;
        end
      end
      WAIT_RX: begin
        if (phase_q == RX_WAIT_RISE) begin
          if (bus.status_in) phase_d = RX_WAIT_FALL;
        end else if (!bus.status_in) begin
          phase_d = RX_WAIT_RISE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout_hit) begin
      state_d = IDLE;
      phase_d = RX_WAIT_RISE;
    end
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      phase_q   <= RX_WAIT_RISE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef SERIALIZADOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q;
  logic             error_q;

  assign timeout_hit   = (state_q == WAIT_RX) && (tmo_q == TMO_LAST);
  assign bus.error_out = error_q;

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      tmo_q <= (state_q == WAIT_RX) ? tmo_q + 1'b1 : '0;
      if (timeout_hit) error_q <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign bus.error_out = 1'b0;
`endif

  // Outputs decode straight from state so an async reset drops write_out immediately.
  assign bus.write_out = (state_q == SHIFT);
  assign bus.data_out  = (state_q == SHIFT) && shift_q[WIDTH-1];
  assign bus.busy_out  = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: latency, bit order, FIFO full/drop, ack handshake, mid-word reset,
// and (with SERIALIZADOR_TIMEOUT_EN) the WAIT_RX watchdog.
module tb_serializador;
  logic clk_100KHz = 1'b0;
  logic reset      = 1'b0;
  int   n_vec      = 0;
  int   n_err      = 0;

  always #5 clk_100KHz = ~clk_100KHz;

  serializador_if #(.WIDTH(8)) bus ();

  serializador #(
    .WIDTH          (8),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .bus        (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_100KHz);
  endtask

  task automatic push(input logic [7:0] d);
    bus.data_in  = d;
    bus.write_in = 1'b1;
    tick();
    bus.write_in = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (bus.write_out !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check({tag, "-start"}, bus.write_out, 1);
  endtask

  task automatic expect_bits(input string tag, input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      check({tag, "-we"}, bus.write_out, 1);
      check({tag, "-bit"}, bus.data_out, d[i]);
      tick();
    end
    check({tag, "-end"}, bus.write_out, 0);
    $display("word %s sent %02h", tag, d);
  endtask

  task automatic ack();
    bus.status_in = 1'b1;
    tick();
    bus.status_in = 1'b0;
    tick();
  endtask

  task automatic quiet(input string tag, input int cycles);
    int writes = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.write_out !== 1'b0) writes++;
      tick();
    end
    check(tag, writes, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] loop_words [3];
    logic [7:0] fill_words [5];
    logic [7:0] rx;

    loop_words = '{8'h3C, 8'hFF, 8'h00};
    fill_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus.data_in   = '0;
    bus.write_in  = 1'b0;
    bus.status_in = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst-we", bus.write_out, 0);
    check("rst-do", bus.data_out, 0);
    check("rst-busy", bus.busy_out, 0);
    check("rst-err", bus.error_out, 0);
    reset = 1'b1;
    tick();
    check("rst-ready", bus.ready_out, 1);

    // Test 1: A5, first bit one cycle after the pop
    push(8'hA5);
    check("t1-lat", bus.write_out, 0);
    tick();
    expect_bits("t1", 8'hA5);
    check("t1-busy", bus.busy_out, 1);
    quiet("t1-hold", 2);

    // Test 6: single-cycle status pulse, next word starts two cycles after it
    push(8'h96);
    bus.status_in = 1'b1;
    tick();
    bus.status_in = 1'b0;
    check("t6-fall", bus.write_out, 0);
    tick();
    check("t6-idle", bus.write_out, 0);
    check("t6-busy", bus.busy_out, 1);
    tick();
    expect_bits("t6", 8'h96);
    ack();
    check("t6-done", bus.busy_out, 0);

    // Test 2: far-end loopback, reassemble each byte from the serial stream
    for (int w = 0; w < 3; w++) begin
      push(loop_words[w]);
      wait_start("t2");
      rx = '0;
      for (int b = 0; b < 8; b++) begin
        rx = {rx[6:0], bus.data_out};
        tick();
      end
      check("t2-byte", rx, loop_words[w]);
      $display("word t2 received %02h", rx);
      ack();
    end
    check("t2-busy", bus.busy_out, 0);

    // Test 3: fill FIFO while far end holds status high; fifth word dropped
    bus.status_in = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3-ready", bus.ready_out, (i < 4) ? 32'd1 : 32'd0);
      push(fill_words[i]);
    end
    check("t3-full", bus.ready_out, 0);
    quiet("t3-hold", 5);
    bus.status_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_start("t3");
      expect_bits("t3", fill_words[i]);
      ack();
    end
    quiet("t3-extra", 20);
    check("t3-busy", bus.busy_out, 0);

`ifdef SERIALIZADOR_TIMEOUT_EN
    // Test 5: status stuck low after a word, watchdog fires at WAIT_RX cycle 16
    push(8'hC3);
    push(8'h5A);
    wait_start("t5");
    expect_bits("t5", 8'hC3);
    repeat (15) tick();
    check("t5-pre", bus.error_out, 0);
    tick();
    check("t5-err", bus.error_out, 1);
    wait_start("t5b");
    expect_bits("t5b", 8'h5A);
    ack();
    check("t5-sticky", bus.error_out, 1);
`endif

    // Test 4: reset three bits into F0 with another word queued
    push(8'hF0);
    push(8'h0F);
    wait_start("t4");
    for (int i = 0; i < 3; i++) begin
      check("t4-bit", bus.data_out, 1);
      tick();
    end
    reset = 1'b0;
    #1;
    check("t4-we", bus.write_out, 0);
    check("t4-do", bus.data_out, 0);
    check("t4-busy", bus.busy_out, 0);
    check("t4-err", bus.error_out, 0);
    tick();
    reset = 1'b1;
    tick();
    check("t4-ready", bus.ready_out, 1);
    quiet("t4-empty", 20);
    check("t4-idle", bus.busy_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
